// File: rtl/mult_seq_ctrl.sv
// Multi-cycle sequencer for the EX-stage multiplier: captures operands, stalls the front end, presents the product.
// Optional zero-operand bypass is enabled by defining MULT_SEQ_ZERO_BYPASS_EN.
module mult_seq_ctrl #(
  parameter int WIDTH       = 64,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_is_mul,
  input  logic             flush,
  input  logic [WIDTH-1:0] fwd_a,
  input  logic [WIDTH-1:0] fwd_b,
  input  logic [WIDTH-1:0] mult_low,
  output logic [WIDTH-1:0] mult_a,
  output logic [WIDTH-1:0] mult_b,
  output logic             stall_out,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result_out
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             start_s;
  logic             zero_op_s;
  logic             cnt_zero_s;

  assign start_s    = ex_valid & ex_is_mul & ~flush & (state_r == IDLE);
  assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});

`ifdef MULT_SEQ_ZERO_BYPASS_EN
  assign zero_op_s = (fwd_a == {WIDTH{1'b0}}) | (fwd_b == {WIDTH{1'b0}});
`else
  assign zero_op_s = 1'b0;
`endif

  // Next-state and combinational handshake outputs; flush overrides stall and result_valid in the same cycle.
  always_comb begin
    state_nxt_s  = state_r;
    stall_out    = 1'b0;
    result_valid = 1'b0;
    case (state_r)
      IDLE: begin
        stall_out = start_s;
        if (start_s) begin
          if (zero_op_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = BUSY;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (flush) begin
          stall_out   = 1'b0;
          state_nxt_s = IDLE;
        end else if (cnt_zero_s) begin
          stall_out   = 1'b1;
          state_nxt_s = DONE;
        end else begin
          stall_out   = 1'b1;
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        result_valid = ~flush;
        state_nxt_s  = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign busy = (state_r != IDLE);

  // State, latency counter, frozen operands and latched product.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      mult_a     <= {WIDTH{1'b0}};
      mult_b     <= {WIDTH{1'b0}};
      result_out <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (start_s) begin
        mult_a <= fwd_a;
        mult_b <= fwd_b;
        cnt_r  <= CNT_W'(MUL_LATENCY - 1);
        if (zero_op_s) begin
          result_out <= {WIDTH{1'b0}};
        end
      end else if ((state_r == BUSY) && !flush) begin
        if (cnt_zero_s) begin
          result_out <= mult_low;
        end else begin
          cnt_r <= cnt_r - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
// Honours MULT_SEQ_ZERO_BYPASS_EN the same way as the design.
module tb_mult_seq_ctrl;
  localparam int W   = 64;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         reset, ex_valid, ex_is_mul, flush;
  logic [W-1:0] fwd_a, fwd_b, mult_low, mult_a, mult_b, result_out;
  logic         stall_out, busy, result_valid;

  int checks = 0;
  int errors = 0;

  // Reference model state: BUSY cycles still owed, pending result cycle, expected registers.
  int           m_left;
  bit           m_done;
  logic [W-1:0] m_ma, m_mb, m_prod, m_res;

  int           cyc;
  int           stall_cnt;
  logic [W-1:0] rv_val[$];
  int           rv_cyc[$];

  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational multiplier array.
  assign mult_low = mult_a * mult_b;

  mult_seq_ctrl #(.WIDTH(W), .MUL_LATENCY(LAT), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_mul(ex_is_mul), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mult_low(mult_low), .mult_a(mult_a), .mult_b(mult_b),
    .stall_out(stall_out), .busy(busy), .result_valid(result_valid), .result_out(result_out)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit is_zero_bypass(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_SEQ_ZERO_BYPASS_EN
    return (a == 64'd0) || (b == 64'd0);
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: drive inputs, compare outputs against the model, then advance the model.
  task automatic step(input logic rs, input logic v, input logic m, input logic f,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    bit in_busy, in_done, st, e_stall, e_rv;
    @(negedge clk);
    reset = rs; ex_valid = v; ex_is_mul = m; flush = f; fwd_a = a; fwd_b = b;
    #1;
    in_busy = (m_left > 0);
    in_done = m_done;
    st      = v && m && !f && !in_busy && !in_done;
    e_stall = in_busy ? !f : st;
    e_rv    = in_done && !f;
    chk("stall_out", {63'd0, stall_out}, {63'd0, e_stall});
    chk("busy", {63'd0, busy}, {63'd0, in_busy || in_done});
    chk("result_valid", {63'd0, result_valid}, {63'd0, e_rv});
    chk("result_out", result_out, m_res);
    chk("mult_a", mult_a, m_ma);
    chk("mult_b", mult_b, m_mb);
    if (stall_out) stall_cnt++;
    if (result_valid) begin
      rv_val.push_back(result_out);
      rv_cyc.push_back(cyc);
    end
    if (rs) begin
      m_left = 0; m_done = 0; m_ma = '0; m_mb = '0; m_res = '0; m_prod = '0;
    end else if (in_done) begin
      m_done = 0;
    end else if (in_busy) begin
      if (f) m_left = 0;
      else if (m_left == 1) begin
        m_left = 0; m_done = 1; m_res = m_prod;
      end else m_left--;
    end else if (st) begin
      m_ma   = a;
      m_mb   = b;
      m_prod = $signed(a) * $signed(b);
      if (is_zero_bypass(a, b)) begin
        m_done = 1; m_res = 64'd0;
      end else m_left = LAT;
    end
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
  endtask

  // Issue one MUL and hold it in EX for the given number of cycles.
  task automatic mul_hold(input logic [W-1:0] a, input logic [W-1:0] b, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 1'b0, a, b);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int           sel;
    cyc = 0; stall_cnt = 0;
    m_left = 0; m_done = 0; m_ma = '0; m_mb = '0; m_res = '0; m_prod = '0;
    reset = 1'b1; ex_valid = 1'b0; ex_is_mul = 1'b0; flush = 1'b0; fwd_a = '0; fwd_b = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);

    // 1: non-MUL stream never stalls.
    stall_cnt = 0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 64'(i + 1), 64'(i * 3));
    chk("t1_stalls", 64'(stall_cnt), 64'd0);

    // 2: 3 * -5.
    stall_cnt = 0; rv_val.delete(); rv_cyc.delete();
    mul_hold(64'd3, -64'sd5, LAT + 2);
    idle_cycles(1);
    chk("t2_stalls", 64'(stall_cnt), 64'(LAT + 1));
    chk("t2_pulses", 64'(rv_val.size()), 64'd1);
    if (rv_val.size() > 0) chk("t2_result", rv_val[0], 64'hFFFF_FFFF_FFFF_FFF1);

    // 3: 7 * 6 with operand A changing mid-flight.
    rv_val.delete();
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'd7, 64'd6);
    for (int i = 0; i < LAT + 1; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 64'd100, 64'd6);
      chk("t3_mult_a", mult_a, 64'd7);
    end
    idle_cycles(1);
    chk("t3_pulses", 64'(rv_val.size()), 64'd1);
    if (rv_val.size() > 0) chk("t3_result", rv_val[0], 64'd42);

    // 4: back-to-back MULs.
    rv_val.delete(); rv_cyc.delete();
    mul_hold(64'd2, 64'd3, LAT + 2);
    mul_hold(64'd4, 64'd5, LAT + 2);
    idle_cycles(1);
    chk("t4_pulses", 64'(rv_val.size()), 64'd2);
    if (rv_val.size() == 2) begin
      chk("t4_first", rv_val[0], 64'd6);
      chk("t4_second", rv_val[1], 64'd20);
      chk("t4_spacing", 64'(rv_cyc[1] - rv_cyc[0]), 64'(LAT + 2));
    end

    // 5: flush in the BUSY cycle where the counter reads 2, then reset mid-BUSY.
    rv_val.delete();
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'd9, 64'd9);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'd9, 64'd9);
    step(1'b0, 1'b1, 1'b1, 1'b1, 64'd9, 64'd9);
    chk("t5_flush_stall", {63'd0, stall_out}, 64'd0);
    idle_cycles(1);
    chk("t5_idle", {63'd0, busy}, 64'd0);
    chk("t5_kept", result_out, 64'd20);
    chk("t5_pulses", 64'(rv_val.size()), 64'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'd11, 64'd13);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'd11, 64'd13);
    step(1'b1, 1'b1, 1'b1, 1'b0, 64'd11, 64'd13);
    idle_cycles(1);
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_mult_a", mult_a, 64'd0);
    chk("t5_rst_result", result_out, 64'd0);

    // 6: zero operand.
    stall_cnt = 0; rv_val.delete();
    mul_hold(64'd0, 64'd9, 1);
    for (int i = 0; i < LAT + 1 && rv_val.size() == 0; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 64'd9);
    idle_cycles(1);
`ifdef MULT_SEQ_ZERO_BYPASS_EN
    chk("t6_stalls", 64'(stall_cnt), 64'd1);
`else
    chk("t6_stalls", 64'(stall_cnt), 64'(LAT + 1));
`endif
    chk("t6_pulses", 64'(rv_val.size()), 64'd1);
    if (rv_val.size() > 0) chk("t6_result", rv_val[0], 64'd0);

    // Randomized traffic with occasional flushes, resets and zero operands.
    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      if (sel == 0) ra = 64'd0;
      if (sel == 1) rb = 64'($signed(-$urandom_range(0, 50)));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 5) != 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
